// File: rtl/prince_masked_round_iter.sv
// Iterative 4-share threshold-implementation PRINCE round controller; S-box chaining guards b/c/d carried between rounds.
// Optional macro PRINCE_ROUND_REMASK_EN adds port fresh_rnd and refreshes shares w/x on every share-register write.
module prince_masked_round_iter #(
  parameter int FWD_ROUNDS = 5,
  parameter int BWD_ROUNDS = 5,
  parameter int PIPE_SBOX  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in_w,
  input  logic [63:0] in_x,
  input  logic [63:0] in_y,
  input  logic [63:0] in_z,
  input  logic [3:0]  b_init,
  input  logic [3:0]  c_init,
  input  logic [3:0]  d_init,
`ifdef PRINCE_ROUND_REMASK_EN
  input  logic [63:0] fresh_rnd,
`endif
  output logic [3:0]  rc_idx,
  input  logic [63:0] rc,
  output logic        busy,
  output logic        done,
  output logic [63:0] out_w,
  output logic [63:0] out_x,
  output logic [63:0] out_y,
  output logic [63:0] out_z,
  output logic        out_valid
);
  localparam logic [3:0]  FWD_L  = 4'(FWD_ROUNDS);
  localparam logic [3:0]  LAST_L = 4'(FWD_ROUNDS + BWD_ROUNDS - 1);
  localparam logic [63:0] SBOX_T = 64'hBF32AC916780E5D4;
  localparam logic [63:0] SINV_T = 64'hB732FD89A6405EC1;
  localparam logic [63:0] SR_P   = 64'h05AF49E38D27C16B;
  localparam logic [63:0] SR_I   = 64'h0DA741EB852FC963;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [63:0] sw_q, sx_q, sy_q, sz_q;
  logic [3:0]  b_q, c_q, d_q;
  logic [63:0] pw_p1_q, px_p1_q, py_p1_q, pz_p1_q;
  logic [3:0]  pb_p1_q, pc_p1_q, pd_p1_q;
  logic [63:0] ow_q, ox_q, oy_q, oz_q;
  logic        ov_q;
  logic        load, pipe_we, share_we, last, inv;
  logic [63:0] sbw, sbx, sby, sbz;
  logic [3:0]  nb, nc, nd, cb, cc, cd;
  logic [63:0] lw, lx, ly, lz;
  logic [63:0] rw, rx, ry, rz;

  function automatic logic [3:0] sb(input logic iv, input logic [3:0] a);
    logic [63:0] t;
    t = iv ? SINV_T : SBOX_T;
    return t[63 - 4*int'(a) -: 4];
  endfunction

  // Direct sharing: every 4-bit bijection is at most cubic, so F(a0^a1^a2^a3) is the XOR of F over all
  // proper share subsets; each term goes to an output share whose index it does not touch.
  function automatic logic [15:0] ti_sbox(input logic iv, input logic [3:0] a0, a1, a2, a3);
    logic [3:0] o0, o1, o2, o3;
    o0 = sb(iv, a1^a2^a3) ^ sb(iv, a1^a2) ^ sb(iv, a1^a3) ^ sb(iv, a2^a3) ^ sb(iv, a3) ^ sb(iv, 4'h0);
    o1 = sb(iv, a0^a2^a3) ^ sb(iv, a0^a2) ^ sb(iv, a0^a3) ^ sb(iv, a0);
    o2 = sb(iv, a0^a1^a3) ^ sb(iv, a0^a1) ^ sb(iv, a1);
    o3 = sb(iv, a0^a1^a2) ^ sb(iv, a2);
    return {o0, o1, o2, o3};
  endfunction

  function automatic logic [15:0] mhat(input logic [15:0] v, input int s);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 4; i++)
          if (((i + j + s) % 4) != k) r[15-4*j-k] = r[15-4*j-k] ^ v[15-4*i-k];
    return r;
  endfunction

  function automatic logic [63:0] mprime(input logic [63:0] v);
    return {mhat(v[63:48], 0), mhat(v[47:32], 1), mhat(v[31:16], 1), mhat(v[15:0], 0)};
  endfunction

  function automatic logic [63:0] nib_perm(input logic [63:0] v, input logic [63:0] p);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[63-4*i -: 4] = v[63 - 4*int'(p[63-4*i -: 4]) -: 4];
    return r;
  endfunction

  function automatic logic [63:0] linear(input logic [63:0] v, input logic iv);
    return iv ? mprime(nib_perm(v, SR_I)) : nib_perm(mprime(v), SR_P);
  endfunction

  assign inv = (cnt_q >= FWD_L);

  // Stage p0: shared S-box layer, guards spread over shares so their XOR cancels
  always_comb begin
    sbw = '0; sbx = '0; sby = '0; sbz = '0;
    nb = '0; nc = '0; nd = '0;
    for (int j = 0; j < 16; j++) begin
      logic [15:0] t;
      t = ti_sbox(inv, sw_q[63-4*j -: 4], sx_q[63-4*j -: 4], sy_q[63-4*j -: 4], sz_q[63-4*j -: 4]);
      sbw[63-4*j -: 4] = t[15:12] ^ b_q ^ c_q ^ d_q;
      sbx[63-4*j -: 4] = t[11:8] ^ b_q;
      sby[63-4*j -: 4] = t[7:4] ^ c_q;
      sbz[63-4*j -: 4] = t[3:0] ^ d_q;
      if (j == 0) begin
        nb = t[11:8]; nc = t[7:4]; nd = t[3:0];
      end
    end
  end

  // Stage p1: linear layer and round constant, from the pipe register when PIPE_SBOX is set
  assign lw = (PIPE_SBOX != 0) ? pw_p1_q : sbw;
  assign lx = (PIPE_SBOX != 0) ? px_p1_q : sbx;
  assign ly = (PIPE_SBOX != 0) ? py_p1_q : sby;
  assign lz = (PIPE_SBOX != 0) ? pz_p1_q : sbz;
  assign cb = (PIPE_SBOX != 0) ? pb_p1_q : nb;
  assign cc = (PIPE_SBOX != 0) ? pc_p1_q : nc;
  assign cd = (PIPE_SBOX != 0) ? pd_p1_q : nd;

  always_comb begin
    rw = linear(lw, inv) ^ rc;
    rx = linear(lx, inv);
    ry = linear(ly, inv);
    rz = linear(lz, inv);
`ifdef PRINCE_ROUND_REMASK_EN
    rw = rw ^ fresh_rnd;
    rx = rx ^ fresh_rnd;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    load     = 1'b0;
    pipe_we  = 1'b0;
    share_we = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        load    = 1'b1;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (PIPE_SBOX != 0 && !phase_q) begin
          pipe_we = 1'b1;
          phase_d = 1'b1;
        end else begin
          share_we = 1'b1;
          phase_d  = 1'b0;
          if (cnt_q == LAST_L) begin
            last    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sw_q <= '0; sx_q <= '0; sy_q <= '0; sz_q <= '0;
      b_q  <= '0; c_q  <= '0; d_q  <= '0;
      pw_p1_q <= '0; px_p1_q <= '0; py_p1_q <= '0; pz_p1_q <= '0;
      pb_p1_q <= '0; pc_p1_q <= '0; pd_p1_q <= '0;
      ow_q <= '0; ox_q <= '0; oy_q <= '0; oz_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (load) begin
        sw_q <= in_w; sx_q <= in_x; sy_q <= in_y; sz_q <= in_z;
        b_q  <= b_init; c_q <= c_init; d_q <= d_init;
        ov_q <= 1'b0;
      end else if (share_we) begin
        sw_q <= rw; sx_q <= rx; sy_q <= ry; sz_q <= rz;
        b_q  <= cb; c_q <= cc; d_q <= cd;
      end
      if (pipe_we) begin
        pw_p1_q <= sbw; px_p1_q <= sbx; py_p1_q <= sby; pz_p1_q <= sbz;
        pb_p1_q <= nb;  pc_p1_q <= nc;  pd_p1_q <= nd;
      end
      if (last) begin
        ow_q <= rw; ox_q <= rx; oy_q <= ry; oz_q <= rz;
        ov_q <= 1'b1;
      end
    end
  end

  // The result is forwarded in the done cycle itself and registered from the next one
  assign rc_idx    = cnt_q;
  assign busy      = (state_q == RUN);
  assign done      = last;
  assign out_valid = ov_q | last;
  assign out_w     = last ? rw : ow_q;
  assign out_x     = last ? rx : ox_q;
  assign out_y     = last ? ry : oy_q;
  assign out_z     = last ? rz : oz_q;
endmodule

// File: tb/tb_prince_masked_round_iter.sv
// Bench for prince_masked_round_iter: pipelined and single-cycle instances against a nibble-level PRINCE round model.
module tb_prince_masked_round_iter;
  localparam int FWD = 5;
  localparam int BWD = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start1 = 1'b0, start0 = 1'b0;
  logic [63:0] in_w = '0, in_x = '0, in_y = '0, in_z = '0;
  logic [3:0]  b_init = '0, c_init = '0, d_init = '0;
  logic [3:0]  ridx1, ridx0;
  logic [63:0] rc1, rc0;
  logic        busy1, done1, ov1, busy0, done0, ov0;
  logic [63:0] ow1, ox1, oy1, oz1, ow0, ox0, oy0, oz0;
  int errs = 0;
  int checks = 0;

`ifdef PRINCE_ROUND_REMASK_EN
  logic [63:0] fresh = '0;
  always @(negedge clk) fresh = {$urandom, $urandom};
`endif

  function automatic logic [63:0] rc_of(input int i);
    case (i)
      0: return 64'h13198a2e03707344;
      1: return 64'ha4093822299f31d0;
      2: return 64'h082efa98ec4e6c89;
      3: return 64'h452821e638d01377;
      4: return 64'hbe5466cf34e90c6c;
      5: return 64'h7ef84f78fd955cb1;
      6: return 64'h85840851f1ac43aa;
      7: return 64'hc882d32f25323c54;
      8: return 64'h64a51195e0e3610d;
      9: return 64'hd3b5a399ca0c2399;
      default: return 64'h0;
    endcase
  endfunction

  assign rc1 = rc_of(int'(ridx1));
  assign rc0 = rc_of(int'(ridx0));

  prince_masked_round_iter #(.FWD_ROUNDS(FWD), .BWD_ROUNDS(BWD), .PIPE_SBOX(1)) dut (
    .clk(clk), .rst(rst), .start(start1),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .b_init(b_init), .c_init(c_init), .d_init(d_init),
`ifdef PRINCE_ROUND_REMASK_EN
    .fresh_rnd(fresh),
`endif
    .rc_idx(ridx1), .rc(rc1), .busy(busy1), .done(done1),
    .out_w(ow1), .out_x(ox1), .out_y(oy1), .out_z(oz1), .out_valid(ov1));

  prince_masked_round_iter #(.FWD_ROUNDS(FWD), .BWD_ROUNDS(BWD), .PIPE_SBOX(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .b_init(b_init), .c_init(c_init), .d_init(d_init),
`ifdef PRINCE_ROUND_REMASK_EN
    .fresh_rnd(fresh),
`endif
    .rc_idx(ridx0), .rc(rc0), .busy(busy0), .done(done0),
    .out_w(ow0), .out_x(ox0), .out_y(oy0), .out_z(oz0), .out_valid(ov0));

  // Unmasked reference: S layer, M' as block matrix of masked identities, ShiftRows, constant
  function automatic logic [63:0] golden(input logic [63:0] pt);
    logic [3:0] st[16], tmp[16], sbt[16], sit[16];
    int srp[16];
    logic [63:0] rk, res;
    sbt = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1, 4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    srp = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    for (int v = 0; v < 16; v++) sit[sbt[v]] = 4'(v);
    for (int i = 0; i < 16; i++) st[i] = pt[63-4*i -: 4];
    for (int r = 0; r < FWD + BWD; r++) begin
      for (int i = 0; i < 16; i++) st[i] = (r >= FWD) ? sit[st[i]] : sbt[st[i]];
      if (r >= FWD) begin
        for (int i = 0; i < 16; i++) tmp[srp[i]] = st[i];
        st = tmp;
      end
      for (int c = 0; c < 4; c++) begin
        int s;
        s = (c == 1 || c == 2) ? 1 : 0;
        for (int j = 0; j < 4; j++) begin
          logic [3:0] acc;
          acc = '0;
          for (int i = 0; i < 4; i++) acc ^= st[4*c+i] & ~(4'b1000 >> ((i + j + s) % 4));
          tmp[4*c+j] = acc;
        end
      end
      st = tmp;
      if (r < FWD) begin
        for (int i = 0; i < 16; i++) tmp[i] = st[srp[i]];
        st = tmp;
      end
      rk = rc_of(r);
      for (int i = 0; i < 16; i++) st[i] ^= rk[63-4*i -: 4];
    end
    for (int i = 0; i < 16; i++) res[63-4*i -: 4] = st[i];
    return res;
  endfunction

  function automatic logic [63:0] unmask(input logic [255:0] r);
    return r[255:192] ^ r[191:128] ^ r[127:64] ^ r[63:0];
  endfunction

  task automatic set_shares(input logic [63:0] pt);
    in_w = {$urandom, $urandom};
    in_x = {$urandom, $urandom};
    in_y = {$urandom, $urandom};
    in_z = pt ^ in_w ^ in_x ^ in_y;
    b_init = 4'($urandom); c_init = 4'($urandom); d_init = 4'($urandom);
  endtask

  // Called right after a falling edge with inputs already set; leaves one cycle after the later done
  task automatic run_txn(output logic [255:0] r1, output logic [255:0] r0, output int lat1, output int lat0);
    start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    in_w = {$urandom, $urandom}; in_x = {$urandom, $urandom};
    lat1 = -1; lat0 = -1; r1 = '0; r0 = '0;
    checks++;
    if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
      errs++; $display("FAIL out_valid_cleared: got %b/%b want 0/0", ov1, ov0);
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done1 === 1'b1 && lat1 < 0) begin lat1 = cyc; r1 = {ow1, ox1, oy1, oz1}; end
      if (done0 === 1'b1 && lat0 < 0) begin lat0 = cyc; r0 = {ow0, ox0, oy0, oz0}; end
      if (lat1 >= 0 && lat0 >= 0) break;
      @(negedge clk);
    end
    if (lat1 < 0 || lat0 < 0) begin
      checks++; errs++;
      $display("FAIL done_timeout: got lat1=%0d lat0=%0d want 20/10", lat1, lat0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy1, done1, ov1, ridx1} !== 7'd0 || {ow1, ox1, oy1, oz1} !== 256'd0) begin
      errs++; $display("FAIL reset_p1: got busy=%b done=%b ov=%b idx=%0d want all 0", busy1, done1, ov1, ridx1);
    end
    checks++;
    if ({busy0, done0, ov0, ridx0} !== 7'd0 || {ow0, ox0, oy0, oz0} !== 256'd0) begin
      errs++; $display("FAIL reset_p0: got busy=%b done=%b ov=%b idx=%0d want all 0", busy0, done0, ov0, ridx0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unmasked();
    logic [255:0] r1, r0;
    int l1, l0;
    logic [63:0] exp;
    exp = golden(64'h0123456789ABCDEF);
    in_w = 64'h0123456789ABCDEF; in_x = '0; in_y = '0; in_z = '0;
    b_init = '0; c_init = '0; d_init = '0;
    run_txn(r1, r0, l1, l0);
    checks++;
    if (unmask(r1) !== exp) begin errs++; $display("FAIL unmasked_p1: got %h want %h", unmask(r1), exp); end
    checks++;
    if (unmask(r0) !== exp) begin errs++; $display("FAIL unmasked_p0: got %h want %h", unmask(r0), exp); end
    checks++;
    if (l1 != 20) begin errs++; $display("FAIL latency_p1: got %0d want 20", l1); end
    checks++;
    if (l0 != 10) begin errs++; $display("FAIL latency_p0: got %0d want 10", l0); end
  endtask

  task automatic test_random_sharing();
    logic [255:0] r1, r0;
    int l1, l0;
    logic [63:0] pt, exp, first_w;
    logic differ;
    differ = 1'b0; first_w = '0;
    for (int n = 0; n < 110; n++) begin
      pt = (n < 100) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
      exp = golden(pt);
      set_shares(pt);
      run_txn(r1, r0, l1, l0);
      checks++;
      if (unmask(r1) !== exp) begin errs++; $display("FAIL shared_p1[%0d]: got %h want %h", n, unmask(r1), exp); end
      checks++;
      if (unmask(r0) !== exp) begin errs++; $display("FAIL shared_p0[%0d]: got %h want %h", n, unmask(r0), exp); end
      if (n == 0) first_w = r1[255:192];
      else if (n < 100 && r1[255:192] !== first_w) differ = 1'b1;
    end
    checks++;
    if (differ !== 1'b1) begin errs++; $display("FAIL share_variation: got %b want 1", differ); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pt, exp;
    pt = {$urandom, $urandom};
    exp = golden(pt);
    set_shares(pt);
    start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 22; cyc++) begin
      start1 = (cyc == 5 || cyc == 20);
      start0 = (cyc == 5 || cyc == 10);
      in_w = {$urandom, $urandom}; in_y = {$urandom, $urandom};
      b_init = 4'($urandom);
      checks++;
      if (busy1 !== (cyc <= 20) || done1 !== (cyc == 20) || ov1 !== (cyc >= 20)) begin
        errs++; $display("FAIL hs_p1[%0d]: got busy=%b done=%b ov=%b", cyc, busy1, done1, ov1);
      end
      checks++;
      if (busy0 !== (cyc <= 10) || done0 !== (cyc == 10) || ov0 !== (cyc >= 10)) begin
        errs++; $display("FAIL hs_p0[%0d]: got busy=%b done=%b ov=%b", cyc, busy0, done0, ov0);
      end
      if (cyc <= 20) begin
        checks++;
        if (ridx1 !== 4'((cyc - 1) / 2)) begin
          errs++; $display("FAIL rc_idx_p1[%0d]: got %0d want %0d", cyc, ridx1, (cyc - 1) / 2);
        end
      end
      if (cyc <= 10) begin
        checks++;
        if (ridx0 !== 4'(cyc - 1)) begin
          errs++; $display("FAIL rc_idx_p0[%0d]: got %0d want %0d", cyc, ridx0, cyc - 1);
        end
      end
      if (cyc >= 20) begin
        checks++;
        if ((ow1 ^ ox1 ^ oy1 ^ oz1) !== exp) begin
          errs++; $display("FAIL hold_p1[%0d]: got %h want %h", cyc, ow1 ^ ox1 ^ oy1 ^ oz1, exp);
        end
      end
      if (cyc >= 10) begin
        checks++;
        if ((ow0 ^ ox0 ^ oy0 ^ oz0) !== exp) begin
          errs++; $display("FAIL hold_p0[%0d]: got %h want %h", cyc, ow0 ^ ox0 ^ oy0 ^ oz0, exp);
        end
      end
      @(negedge clk);
    end
    start1 = 1'b0; start0 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [255:0] r1, r0;
    int l1, l0;
    logic [63:0] pt, exp;
    set_shares({$urandom, $urandom});
    start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    for (int cyc = 1; cyc < 8; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy1, done1, ov1, ridx1} !== 7'd0 || {ow1, ox1, oy1, oz1} !== 256'd0) begin
      errs++; $display("FAIL midrun_rst_p1: got busy=%b ov=%b idx=%0d out_w=%h want zeros", busy1, ov1, ridx1, ow1);
    end
    checks++;
    if ({busy0, done0, ov0, ridx0} !== 7'd0 || {ow0, ox0, oy0, oz0} !== 256'd0) begin
      errs++; $display("FAIL midrun_rst_p0: got busy=%b ov=%b idx=%0d out_w=%h want zeros", busy0, ov0, ridx0, ow0);
    end
    pt = {$urandom, $urandom};
    exp = golden(pt);
    set_shares(pt);
    run_txn(r1, r0, l1, l0);
    checks++;
    if (unmask(r1) !== exp || l1 != 20) begin
      errs++; $display("FAIL after_rst_p1: got %h lat %0d want %h lat 20", unmask(r1), l1, exp);
    end
    checks++;
    if (unmask(r0) !== exp || l0 != 10) begin
      errs++; $display("FAIL after_rst_p0: got %h lat %0d want %h lat 10", unmask(r0), l0, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unmasked();
    test_random_sharing();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
